// File: rtl/pulpemu_trace_pkg.sv
// Shared types and width helpers for the emulator trace-capture control path.
package pulpemu_trace_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2,
    FLUSH   = 2'd3
  } trace_ctrl_state_e;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int fill_w(input int depth);
    return addr_w(depth) + 1;
  endfunction

endpackage

// File: rtl/pulpemu_trace_ack_sync.sv
// Brings the host flush-done toggle into ref_clk_i and turns each toggle into a one-cycle pulse.
module pulpemu_trace_ack_sync (
  input  logic ref_clk_i,
  input  logic rst_ni,
  input  logic ack_tgl_i,
  output logic ack_pulse_o
);

  logic sync1_q, sync2_q, edge_q;

  always_ff @(posedge ref_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= ack_tgl_i;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
    end
  end

  assign ack_pulse_o = sync2_q ^ edge_q;

endmodule

// File: rtl/pulpemu_trace_flush_ctrl.sv
// Trace-buffer capture sequencer: write pointer, fill level, core stall, host flush handshake.
module pulpemu_trace_flush_ctrl
  import pulpemu_trace_pkg::*;
#(
  parameter int unsigned BUF_DEPTH    = 1024,
  parameter int unsigned THRESHOLD    = 1000,
  parameter int unsigned QUIET_CYCLES = 8,
  parameter int unsigned DROP_W       = 16,
  localparam int unsigned ADDR_W      = addr_w(BUF_DEPTH),
  localparam int unsigned FILL_W      = fill_w(BUF_DEPTH)
) (
  input  logic              ref_clk_i,
  input  logic              rst_ni,
  input  logic              fetch_en_i,
  input  logic              entry_valid_i,
  output logic              entry_ready_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic              trace_wait_o,
  output logic              flush_req_o,
  output logic [FILL_W-1:0] fill_level_o,
  input  logic              host_ack_tgl_i,
  output logic [DROP_W-1:0] drop_cnt_o
);

  localparam int unsigned QW = $clog2(QUIET_CYCLES + 1);

  trace_ctrl_state_e state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [FILL_W-1:0] fill_q;
  logic [QW-1:0]     quiet_q, quiet_d;
  logic [DROP_W-1:0] drop_q;
  logic              wait_q, flush_req_q;
  logic              ack_pulse, wr_en, drop_en, flush_clr;

  pulpemu_trace_ack_sync i_ack_sync (
    .ref_clk_i  (ref_clk_i),
    .rst_ni     (rst_ni),
    .ack_tgl_i  (host_ack_tgl_i),
    .ack_pulse_o(ack_pulse)
  );

  always_comb begin
    state_d   = state_q;
    quiet_d   = '0;
    flush_clr = 1'b0;
    wr_en     = entry_valid_i && (state_q == CAPTURE || state_q == DRAIN)
                && (fill_q < FILL_W'(BUF_DEPTH));
    drop_en   = entry_valid_i && !wr_en;
    unique case (state_q)
      IDLE: begin
        if (fetch_en_i) state_d = CAPTURE;
      end
      CAPTURE: begin
        if (fill_q >= FILL_W'(THRESHOLD) || (!fetch_en_i && fill_q != '0)) state_d = DRAIN;
        else if (!fetch_en_i) state_d = IDLE;
      end
      DRAIN: begin
        // Any entry still trickling out of the FIFO restarts the quiet window.
        if (!entry_valid_i && quiet_q != QW'(QUIET_CYCLES)) quiet_d = quiet_q + QW'(1);
        else if (!entry_valid_i) quiet_d = quiet_q;
        if (quiet_d == QW'(QUIET_CYCLES)) state_d = FLUSH;
      end
      FLUSH: begin
        if (ack_pulse) begin
          flush_clr = 1'b1;
          state_d   = fetch_en_i ? CAPTURE : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ref_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      quiet_q     <= '0;
      drop_q      <= '0;
      wait_q      <= 1'b0;
      flush_req_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      quiet_q     <= quiet_d;
      flush_req_q <= (state_d == FLUSH);
      if (flush_clr) begin
        wr_ptr_q <= '0;
        fill_q   <= '0;
        wait_q   <= 1'b0;
      end else begin
        if (fill_q >= FILL_W'(THRESHOLD)) wait_q <= 1'b1;
        if (wr_en) begin
          wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
          fill_q   <= fill_q + FILL_W'(1);
        end
      end
      if (drop_en && drop_q != '1) drop_q <= drop_q + DROP_W'(1);
    end
  end

  assign entry_ready_o = rst_ni;
  assign wr_en_o       = wr_en;
  assign wr_addr_o     = wr_ptr_q;
  assign trace_wait_o  = wait_q;
  assign flush_req_o   = flush_req_q;
  assign fill_level_o  = fill_q;
  assign drop_cnt_o    = drop_q;

endmodule

// File: tb/tb_pulpemu_trace_flush_ctrl.sv
// Directed scenarios plus randomized traffic, checked every cycle against a behavioural model.
module tb_pulpemu_trace_flush_ctrl;

  localparam int DEPTH    = 16;
  localparam int TH       = 12;
  localparam int QUIET    = 8;
  localparam int DROP_W   = 6;
  localparam int DROP_MAX = (1 << DROP_W) - 1;
  localparam int M_IDLE = 0, M_CAP = 1, M_DRN = 2, M_FL = 3;

  logic ref_clk_i = 1'b0;
  logic rst_ni, fetch_en_i, entry_valid_i, host_ack_tgl_i;
  logic entry_ready_o, wr_en_o, trace_wait_o, flush_req_o;
  logic [3:0] wr_addr_o;
  logic [4:0] fill_level_o;
  logic [DROP_W-1:0] drop_cnt_o;

  int tests = 0, fails = 0;

  // Behavioural model state
  int m_mode, m_fill, m_ptr, m_quiet, m_drop;
  bit m_wait, m_freq;
  bit [2:0] m_seen;

  pulpemu_trace_flush_ctrl #(
    .BUF_DEPTH(DEPTH), .THRESHOLD(TH), .QUIET_CYCLES(QUIET), .DROP_W(DROP_W)
  ) dut (
    .ref_clk_i(ref_clk_i), .rst_ni(rst_ni), .fetch_en_i(fetch_en_i),
    .entry_valid_i(entry_valid_i), .entry_ready_o(entry_ready_o),
    .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .trace_wait_o(trace_wait_o),
    .flush_req_o(flush_req_o), .fill_level_o(fill_level_o),
    .host_ack_tgl_i(host_ack_tgl_i), .drop_cnt_o(drop_cnt_o)
  );

  always #5 ref_clk_i = ~ref_clk_i;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_fill = 0; m_ptr = 0; m_quiet = 0; m_drop = 0;
    m_wait = 0; m_freq = 0; m_seen = '0;
  endtask

  // One rising edge of the reference behaviour, using the inputs present at that edge.
  task automatic model_step();
    bit pulse, wr;
    int nmode;
    pulse = m_seen[1] ^ m_seen[2];
    m_seen = {m_seen[1:0], host_ack_tgl_i};
    wr = entry_valid_i && (m_mode == M_CAP || m_mode == M_DRN) && m_fill < DEPTH;
    if (entry_valid_i && !wr && m_drop < DROP_MAX) m_drop++;
    nmode = m_mode;
    case (m_mode)
      M_IDLE: if (fetch_en_i) nmode = M_CAP;
      M_CAP: begin
        if (m_fill >= TH || (!fetch_en_i && m_fill > 0)) nmode = M_DRN;
        else if (!fetch_en_i) nmode = M_IDLE;
      end
      M_DRN: begin
        m_quiet = entry_valid_i ? 0 : m_quiet + 1;
        if (m_quiet >= QUIET) nmode = M_FL;
      end
      default: begin
        if (pulse) begin
          m_fill = 0; m_ptr = 0; m_wait = 0;
          nmode = fetch_en_i ? M_CAP : M_IDLE;
        end
      end
    endcase
    if (m_mode != M_DRN) m_quiet = 0;
    if (!(m_mode == M_FL && pulse)) begin
      if (m_fill >= TH) m_wait = 1;
      if (wr) begin
        m_fill++;
        m_ptr = (m_ptr + 1) % DEPTH;
      end
    end
    m_mode = nmode;
    m_freq = (nmode == M_FL);
  endtask

  task automatic tick();
    @(posedge ref_clk_i);
    if (rst_ni) model_step();
    #1;
  endtask

  task automatic wait_flush(input string name, input int budget);
    int n = 0;
    while (!flush_req_o && n < budget) begin
      tick();
      n++;
    end
    check({name, "_flush_timeout"}, flush_req_o, 1);
  endtask

  always @(negedge ref_clk_i) begin
    if (rst_ni) begin
      check("entry_ready", entry_ready_o, 1);
      check("wr_en", wr_en_o, entry_valid_i && (m_mode == M_CAP || m_mode == M_DRN) && m_fill < DEPTH);
      check("wr_addr", wr_addr_o, m_ptr);
      check("fill", fill_level_o, m_fill);
      check("trace_wait", trace_wait_o, m_wait);
      check("flush_req", flush_req_o, m_freq);
      check("drop_cnt", drop_cnt_o, m_drop);
    end
  end

  initial begin
    int d;
    int ack_delay;
    int cool;
    rst_ni = 0; fetch_en_i = 0; entry_valid_i = 0; host_ack_tgl_i = 0;
    model_reset();
    repeat (3) tick();
    rst_ni = 1;
    tick();
    check("rst_fill", fill_level_o, 0);
    check("rst_addr", wr_addr_o, 0);
    check("rst_wait", trace_wait_o, 0);
    check("rst_flush", flush_req_o, 0);
    check("rst_drop", drop_cnt_o, 0);
    $display("[TB] reset state checked");

    // 1: twelve back-to-back entries reach the threshold
    fetch_en_i = 1;
    tick();
    entry_valid_i = 1;
    repeat (12) tick();
    check("t1_fill", fill_level_o, 12);
    check("t1_addr", wr_addr_o, 12);
    check("t1_wait_pre", trace_wait_o, 0);
    tick();
    check("t1_wait", trace_wait_o, 1);
    $display("[TB] threshold stall: fill=%0d wait=%0d", fill_level_o, trace_wait_o);

    // 2: overfill, then go quiet
    repeat (5) tick();
    check("t2_fill", fill_level_o, 16);
    check("t2_drop", drop_cnt_o, 2);
    entry_valid_i = 0;
    repeat (7) tick();
    check("t2_flush_early", flush_req_o, 0);
    tick();
    check("t2_flush", flush_req_o, 1);
    check("t2_fill_hold", fill_level_o, 16);
    $display("[TB] flush request: fill=%0d drop=%0d", fill_level_o, drop_cnt_o);

    // 3: host ack takes three edges
    host_ack_tgl_i = ~host_ack_tgl_i;
    repeat (2) tick();
    check("t3_flush_hold", flush_req_o, 1);
    tick();
    check("t3_fill", fill_level_o, 0);
    check("t3_flush", flush_req_o, 0);
    check("t3_wait", trace_wait_o, 0);
    entry_valid_i = 1;
    @(negedge ref_clk_i); #1;
    check("t3_wr_en", wr_en_o, 1);
    check("t3_addr", wr_addr_o, 0);
    tick();
    $display("[TB] ack resumed capture at address 0");

    // 4: stopping the cores forces a partial flush
    repeat (4) tick();
    check("t4_fill", fill_level_o, 5);
    entry_valid_i = 0; fetch_en_i = 0;
    wait_flush("t4", 20);
    check("t4_fill_flush", fill_level_o, 5);
    host_ack_tgl_i = ~host_ack_tgl_i;
    repeat (3) tick();
    check("t4_flush_done", flush_req_o, 0);
    entry_valid_i = 1;
    d = drop_cnt_o;
    repeat (3) tick();
    check("t4_idle_drop", drop_cnt_o, d + 3);
    check("t4_idle_fill", fill_level_o, 0);
    entry_valid_i = 0;
    $display("[TB] partial flush, then idle drops=%0d", drop_cnt_o);

    // 5: stray ack outside FLUSH, and entry colliding with the ack pulse
    fetch_en_i = 1;
    tick();
    entry_valid_i = 1;
    repeat (3) tick();
    entry_valid_i = 0;
    host_ack_tgl_i = ~host_ack_tgl_i;
    repeat (4) tick();
    check("t5_stray_fill", fill_level_o, 3);
    check("t5_stray_flush", flush_req_o, 0);
    fetch_en_i = 0;
    wait_flush("t5", 20);
    host_ack_tgl_i = ~host_ack_tgl_i;
    repeat (2) tick();
    entry_valid_i = 1;
    d = drop_cnt_o;
    tick();
    check("t5_collide_fill", fill_level_o, 0);
    check("t5_collide_drop", drop_cnt_o, d + 1);
    entry_valid_i = 0;
    $display("[TB] collision: drop=%0d fill=%0d", drop_cnt_o, fill_level_o);

    // 6: asynchronous reset in the middle of DRAIN
    fetch_en_i = 1;
    tick();
    entry_valid_i = 1;
    repeat (9) tick();
    check("t6_fill", fill_level_o, 9);
    entry_valid_i = 0; fetch_en_i = 0;
    repeat (3) tick();
    #2 rst_ni = 0;
    model_reset();
    #1;
    check("t6_rst_fill", fill_level_o, 0);
    check("t6_rst_addr", wr_addr_o, 0);
    check("t6_rst_drop", drop_cnt_o, 0);
    check("t6_rst_ready", entry_ready_o, 0);
    check("t6_rst_wr_en", wr_en_o, 0);
    tick();
    rst_ni = 1;
    fetch_en_i = 1;
    tick();
    entry_valid_i = 1;
    @(negedge ref_clk_i); #1;
    check("t6_restart_addr", wr_addr_o, 0);
    check("t6_restart_wr", wr_en_o, 1);
    tick();
    entry_valid_i = 0;
    $display("[TB] mid-drain reset restarts at address 0");

    // Randomized traffic with a host that answers flush requests after a random delay
    ack_delay = -1;
    cool = 0;
    for (int i = 0; i < 4000; i++) begin
      entry_valid_i = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 39) == 0) fetch_en_i = ~fetch_en_i;
      if (cool > 0) cool--;
      if (flush_req_o && ack_delay < 0 && cool == 0) ack_delay = $urandom_range(0, 6);
      if (ack_delay == 0) begin
        host_ack_tgl_i = ~host_ack_tgl_i;
        cool = 5;
      end
      if (ack_delay >= 0) ack_delay--;
      if ($urandom_range(0, 199) == 0) host_ack_tgl_i = ~host_ack_tgl_i;
      if ($urandom_range(0, 1499) == 0) begin
        #2 rst_ni = 0;
        model_reset();
        ack_delay = -1;
        tick();
        rst_ni = 1;
      end
      tick();
    end
    $display("[TB] random phase done, drop=%0d", drop_cnt_o);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
